// File: rtl/display_scoreboard.sv
// Two seven-segment score digits for a 160x120 VGA raster. Scores are latched at
// frame start so a digit never changes mid-frame; outputs lag the pixel by one clock.
module display_scoreboard #(
    parameter int unsigned PLAYER_X0    = 60,
    parameter int unsigned AI_X0        = 88,
    parameter int unsigned DIGIT_Y0     = 4,
    parameter logic [2:0]  PLAYER_COLOR = 3'b010,
    parameter logic [2:0]  AI_COLOR     = 3'b100
) (
    input  logic       VGA_CLK,
    input  logic       resetn,
    input  logic [7:0] xvga,
    input  logic [6:0] yvga,
    input  logic [3:0] player_score,
    input  logic [3:0] ai_score,
    output logic       display_player,
    output logic       display_ai,
    output logic [2:0] player_color,
    output logic [2:0] ai_color
);

    localparam int unsigned CELL_W = 12;
    localparam int unsigned CELL_H = 20;
    localparam int unsigned FRAME_W = 160;
    localparam int unsigned FRAME_H = 120;

    // Bounds are held one bit wider than the pixel counters so X0+12 cannot wrap.
    localparam logic [8:0] PX_LO = 9'(PLAYER_X0);
    localparam logic [8:0] PX_HI = 9'(PLAYER_X0 + CELL_W);
    localparam logic [8:0] AX_LO = 9'(AI_X0);
    localparam logic [8:0] AX_HI = 9'(AI_X0 + CELL_W);
    localparam logic [7:0] Y_LO  = 8'(DIGIT_Y0);
    localparam logic [7:0] Y_HI  = 8'(DIGIT_Y0 + CELL_H);

    logic [3:0] player_q;
    logic [3:0] ai_q;

    logic [8:0] x_c;
    logic [7:0] y_c;
    logic       in_frame_c;
    logic       y_in_c;
    logic       p_in_c;
    logic       a_in_c;
    logic [4:0] ly_c;
    logic [3:0] plx_c;
    logic [3:0] alx_c;
    logic       hit_p_c;
    logic       hit_a_c;
    logic       frame_start_c;

    // Segment membership of a local cell coordinate for a given digit value.
    function automatic logic seg_hit(input logic [3:0] lx, input logic [4:0] ly,
                                     input logic [3:0] digit);
        logic [6:0] segs;  // {a,b,c,d,e,f,g}
        logic       left;
        logic       right;
        logic       upper;
        case (digit)
            4'd0:    segs = 7'b1111110;
            4'd1:    segs = 7'b0110000;
            4'd2:    segs = 7'b1101101;
            4'd3:    segs = 7'b1111001;
            4'd4:    segs = 7'b0110011;
            4'd5:    segs = 7'b1011011;
            4'd6:    segs = 7'b1011111;
            4'd7:    segs = 7'b1110000;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1111011;
            default: segs = 7'b0000000;
        endcase
        left  = (lx <= 4'd1);
        right = (lx >= 4'd10);
        upper = (ly <= 5'd9);
        seg_hit = (segs[6] && ly <= 5'd1)
               || (segs[5] && right && upper)
               || (segs[4] && right && !upper)
               || (segs[3] && ly >= 5'd18)
               || (segs[2] && left && !upper)
               || (segs[1] && left && upper)
               || (segs[0] && (ly == 5'd9 || ly == 5'd10));
    endfunction

    // Bounds-gated local coordinates: subtraction only happens inside the cell.
    always_comb begin
        x_c           = {1'b0, xvga};
        y_c           = {1'b0, yvga};
        in_frame_c    = (x_c < 9'(FRAME_W)) && (y_c < 8'(FRAME_H));
        y_in_c        = (y_c >= Y_LO) && (y_c < Y_HI);
        p_in_c        = in_frame_c && y_in_c && (x_c >= PX_LO) && (x_c < PX_HI);
        a_in_c        = in_frame_c && y_in_c && (x_c >= AX_LO) && (x_c < AX_HI);
        ly_c          = y_in_c ? 5'(y_c - Y_LO) : 5'd0;
        plx_c         = p_in_c ? 4'(x_c - PX_LO) : 4'd0;
        alx_c         = a_in_c ? 4'(x_c - AX_LO) : 4'd0;
        hit_p_c       = p_in_c && seg_hit(plx_c, ly_c, player_q);
        hit_a_c       = a_in_c && seg_hit(alx_c, ly_c, ai_q);
        frame_start_c = (xvga == 8'd0) && (yvga == 7'd0);
    end

    always_ff @(posedge VGA_CLK or negedge resetn) begin
        if (!resetn) begin
            player_q       <= 4'd0;
            ai_q           <= 4'd0;
            display_player <= 1'b0;
            display_ai     <= 1'b0;
            player_color   <= 3'b000;
            ai_color       <= 3'b000;
        end else begin
            if (frame_start_c) begin
                player_q <= player_score;
                ai_q     <= ai_score;
            end
            display_player <= hit_p_c;
            display_ai     <= hit_a_c;
            player_color   <= hit_p_c ? PLAYER_COLOR : 3'b000;
            ai_color       <= hit_a_c ? AI_COLOR : 3'b000;
        end
    end

endmodule

// File: tb/tb_display_scoreboard.sv
// Directed bench for display_scoreboard: expectations queued at stimulus time,
// popped and compared once the registered outputs are valid.
module tb_display_scoreboard;

    logic       VGA_CLK;
    logic       resetn;
    logic [7:0] xvga;
    logic [6:0] yvga;
    logic [3:0] player_score;
    logic [3:0] ai_score;
    logic       display_player;
    logic       display_ai;
    logic [2:0] player_color;
    logic [2:0] ai_color;

    typedef struct {
        string tag;
        int    ep;
        int    ea;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Lit-pixel area of each digit in a 12x20 cell (2-pixel strokes, shared corners).
    int   area [16] = '{112, 40, 100, 100, 78, 100, 114, 60, 128, 114, 0, 0, 0, 0, 0, 0};

    display_scoreboard dut (
        .VGA_CLK       (VGA_CLK),
        .resetn        (resetn),
        .xvga          (xvga),
        .yvga          (yvga),
        .player_score  (player_score),
        .ai_score      (ai_score),
        .display_player(display_player),
        .display_ai    (display_ai),
        .player_color  (player_color),
        .ai_color      (ai_color)
    );

    initial VGA_CLK = 1'b0;
    always #5 VGA_CLK = ~VGA_CLK;

    task automatic cmp(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int x, input int y);
        xvga = 8'(x);
        yvga = 7'(y);
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic check_outputs(input string tag, input int ep, input int ea);
        cmp({tag, ".display_player"}, int'(display_player), ep);
        cmp({tag, ".player_color"}, int'(player_color), (ep != 0) ? 2 : 0);
        cmp({tag, ".display_ai"}, int'(display_ai), ea);
        cmp({tag, ".ai_color"}, int'(ai_color), (ea != 0) ? 4 : 0);
    endtask

    task automatic step_chk(input int x, input int y, input string tag, input int ep, input int ea);
        exp_t e;
        sb.push_back('{tag, ep, ea});
        step(x, y);
        e = sb.pop_front();
        check_outputs(e.tag, e.ep, e.ea);
    endtask

    // Frame scan with scores ps/as; window mode covers only the region around both cells.
    task automatic scan(input int ps, input int as, input bit full, input string tag);
        int   ph = 0;
        int   ah = 0;
        int   outside = 0;
        int   xlo = full ? 0 : 50;
        int   xhi = full ? 159 : 109;
        int   yhi = full ? 119 : 29;
        exp_t e;
        player_score = 4'(ps);
        ai_score     = 4'(as);
        sb.push_back('{tag, area[ps], area[as]});
        if (!full) step(0, 0);
        for (int y = 0; y <= yhi; y++) begin
            for (int x = xlo; x <= xhi; x++) begin
                step(x, y);
                if (display_player) begin
                    ph++;
                    if (!(x >= 60 && x < 72 && y >= 4 && y < 24)) outside++;
                end
                if (display_ai) begin
                    ah++;
                    if (!(x >= 88 && x < 100 && y >= 4 && y < 24)) outside++;
                end
            end
        end
        e = sb.pop_front();
        cmp({e.tag, ".player_hits"}, ph, e.ep);
        cmp({e.tag, ".ai_hits"}, ah, e.ea);
        cmp({e.tag, ".outside_hits"}, outside, 0);
    endtask

    initial begin
        resetn       = 1'b0;
        xvga         = 8'd60;
        yvga         = 7'd4;
        player_score = 4'd5;
        ai_score     = 4'd5;
        repeat (3) @(posedge VGA_CLK);
        #1;
        check_outputs("reset_held", 0, 0);

        // Release without a frame start: both digits render the reset value 0.
        resetn = 1'b1;
        step_chk(60, 4, "post_reset_p_seg_a", 1, 0);
        step_chk(88, 4, "post_reset_a_seg_a", 0, 1);

        player_score = 4'd1;
        ai_score     = 4'd0;
        step_chk(0, 0, "frame_start_00", 0, 0);
        step_chk(71, 10, "p1_seg_b", 1, 0);
        step_chk(60, 10, "p1_seg_f_dark", 0, 0);
        step_chk(71, 10, "p1_seg_b_again", 1, 0);

        // Mid-cycle reset must clear outputs without waiting for a clock edge.
        #2;
        resetn = 1'b0;
        #1;
        check_outputs("async_reset", 0, 0);
        #3;
        resetn = 1'b1;
        step_chk(60, 10, "latch_cleared_seg_f", 1, 0);

        player_score = 4'd0;
        step(0, 0);
        step_chk(65, 13, "p0_seg_g_dark", 0, 0);
        player_score = 4'd8;
        step(0, 0);
        step_chk(65, 13, "p8_seg_g", 1, 0);
        step_chk(71, 4, "p8_right_edge_in", 1, 0);
        step_chk(72, 4, "p8_right_edge_out", 0, 0);
        step_chk(59, 4, "p8_left_edge_out", 0, 0);
        step_chk(60, 3, "p8_top_edge_out", 0, 0);
        step_chk(60, 23, "p8_bottom_row_in", 1, 0);
        step_chk(60, 24, "p8_bottom_edge_out", 0, 0);
        step_chk(200, 10, "x_off_frame", 0, 0);
        step_chk(65, 125, "y_off_frame", 0, 0);

        ai_score = 4'd9;
        step(0, 0);
        step_chk(88, 20, "a9_seg_e_dark", 0, 0);
        step_chk(99, 20, "a9_seg_c", 0, 1);
        // Row 24 is the first row below the 20-row cell.
        step_chk(88, 24, "a9_below_cell_left", 0, 0);
        step_chk(99, 24, "a9_below_cell_right", 0, 0);

        ai_score = 4'd1;
        step_chk(90, 4, "a_midframe_hold", 0, 1);
        step_chk(99, 20, "a_midframe_hold_c", 0, 1);
        step(0, 0);
        step_chk(90, 4, "a1_after_frame_seg_a_dark", 0, 0);
        step_chk(99, 20, "a1_after_frame_seg_c", 0, 1);

        scan(12, 15, 1'b1, "blank_full_frame");
        scan(0, 5, 1'b1, "scan_p0_a5");
        scan(1, 6, 1'b0, "scan_p1_a6");
        scan(2, 7, 1'b0, "scan_p2_a7");
        scan(3, 8, 1'b0, "scan_p3_a8");
        scan(4, 9, 1'b0, "scan_p4_a9");
        scan(9, 4, 1'b0, "scan_p9_a4");
        scan(5, 0, 1'b0, "scan_p5_a0");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
